// File: rtl/mul3_recon_serial_if.sv
// Handshake bundle for the serial 3*q + r reconstruction block.
// The master side presents q/r and accepts x/err; the slave side is the block.
interface mul3_recon_serial_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   q;
    logic [1:0]     r;
    logic           out_valid;
    logic           out_ready;
    logic [W+1:0]   x;
    logic           err;

    modport master (
        output in_valid, q, r, out_ready,
        input  in_ready, out_valid, x, err
    );

    modport slave (
        input  in_valid, q, r, out_ready,
        output in_ready, out_valid, x, err
    );
endinterface

// File: rtl/mul3_recon_serial.sv
// Serial reconstruction of a dividend from a divide-by-3 result:
// x = 3*q + r, computed as q + (q << 1) + r, DIGIT bits per clock, LSB first.
// One operation in flight; x/err are held while the result waits, and x keeps
// the last result after the consumer takes it.
module mul3_recon_serial #(
    parameter int W     = 16,
    parameter int DIGIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    mul3_recon_serial_if.slave bus
);
    localparam int N  = W / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((W % DIGIT) != 0) begin : g_bad_digit
        $error("mul3_recon_serial: W must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [W-1:0]       q_sh_r;
    logic               prev_r;
    logic [1:0]         carry_r;
    logic [CW-1:0]      cnt_r;
    logic [W+1:0]       x_r;
    logic               err_r;

    logic [DIGIT-1:0]   a_s;
    logic [DIGIT-1:0]   b_s;
    logic [DIGIT+1:0]   sum_s;
    logic [1:0]         carry_nx_s;
    logic [1:0]         top_s;

    // Digit adder: q digit + (q << 1) digit + running carry, and the final top bits.
    always_comb begin
        a_s        = q_sh_r[DIGIT-1:0];
        // Shifted-q digit: low bits of this digit moved up one, bit above the previous digit at the bottom.
        b_s        = (a_s << 1'b1) | DIGIT'(prev_r);
        sum_s      = (DIGIT+2)'(a_s) + (DIGIT+2)'(b_s) + (DIGIT+2)'(carry_r);
        carry_nx_s = sum_s[DIGIT+1:DIGIT];
        // After the last digit, q[W-1] is the bit shifted out of (q << 1); carry <= 2 so this never overflows.
        top_s      = carry_nx_s + {1'b0, q_sh_r[DIGIT-1]};
    end

    // Next-state decode for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_nx_s = RUN;
                else              state_nx_s = IDLE;
            end
            RUN: begin
                if (cnt_r == LAST) state_nx_s = DONE;
                else               state_nx_s = RUN;
            end
            DONE: begin
                if (bus.out_ready) state_nx_s = IDLE;
                else               state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register plus registered handshake flags decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    // Datapath: latch operands on acceptance, then fold in one digit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_sh_r  <= {W{1'b0}};
            prev_r  <= 1'b0;
            carry_r <= 2'b00;
            cnt_r   <= {CW{1'b0}};
            x_r     <= {(W+2){1'b0}};
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        q_sh_r  <= bus.q;
                        carry_r <= bus.r;
                        prev_r  <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                        // r == 3 is still processed; the flag just travels with the result.
                        err_r   <= (bus.r == 2'd3);
                    end
                end
                RUN: begin
                    q_sh_r  <= q_sh_r >> DIGIT;
                    prev_r  <= q_sh_r[DIGIT-1];
                    carry_r <= carry_nx_s;
                    cnt_r   <= cnt_r + CW'(1);
                    x_r[int'(cnt_r) * DIGIT +: DIGIT] <= sum_s[DIGIT-1:0];
                    if (cnt_r == LAST) begin
                        x_r[W+1:W] <= top_s;
                    end
                end
                DONE: begin
                    // Result held until the consumer takes it.
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.x         = x_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_mul3_recon_serial.sv
// Bench for mul3_recon_serial: three instances (DIGIT = 1, 2, 4), directed steps on
// the DIGIT=2 instance, then a random phase on all three against a 3*q + r scoreboard.
module tb_mul3_recon_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total_cnt = 0;

    logic        in_valid_d  [3];
    logic [15:0] q_d         [3];
    logic [1:0]  r_d         [3];
    logic        out_ready_d [3];
    logic        in_ready_m  [3];
    logic        out_valid_m [3];
    logic [17:0] x_m         [3];
    logic        err_m       [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s[inst %0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int DG = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        localparam int NN = 16 / DG;

        mul3_recon_serial_if #(.W(16)) ifc ();
        mul3_recon_serial #(.W(16), .DIGIT(DG)) dut (.clk(clk), .rst(rst), .bus(ifc));

        assign ifc.in_valid  = in_valid_d[g];
        assign ifc.q         = q_d[g];
        assign ifc.r         = r_d[g];
        assign ifc.out_ready = out_ready_d[g];
        assign in_ready_m[g]  = ifc.in_ready;
        assign out_valid_m[g] = ifc.out_valid;
        assign x_m[g]         = ifc.x;
        assign err_m[g]       = ifc.err;

        logic [17:0] exp_x_q[$];
        logic        exp_e_q[$];
        logic [17:0] ex;
        logic        ee;
        int          acc_cyc = 0;
        logic        ov_prev = 1'b0;

        // Scoreboard: push the model result at acceptance, compare at the output handshake.
        always @(negedge clk) begin
            if (rst) begin
                exp_x_q.delete();
                exp_e_q.delete();
                ov_prev = 1'b0;
            end else begin
                chk("ready_valid_overlap", g, {31'b0, ifc.in_ready & ifc.out_valid}, 32'd0);
                if (ifc.in_valid && ifc.in_ready) begin
                    exp_x_q.push_back(18'(ifc.q) * 18'd3 + 18'(ifc.r));
                    exp_e_q.push_back(ifc.r == 2'd3);
                    acc_cyc = cyc;
                end
                if (ifc.out_valid && !ov_prev) begin
                    chk("latency", g, 32'(cyc - acc_cyc - 1), 32'(NN));
                end
                if (ifc.out_valid && ifc.out_ready) begin
                    if (exp_x_q.size() == 0) begin
                        chk("unexpected_output", g, 32'd1, 32'd0);
                    end else begin
                        ex = exp_x_q.pop_front();
                        ee = exp_e_q.pop_front();
                        chk("sb_x", g, 32'(ifc.x), 32'(ex));
                        chk("sb_err", g, 32'(ifc.err), 32'(ee));
                    end
                end
                ov_prev = ifc.out_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [15:0] qv, input logic [1:0] rv);
        int n;
        q_d[k] = qv;
        r_d[k] = rv;
        in_valid_d[k] = 1'b1;
        n = 0;
        while (!in_ready_m[k] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("send_timeout", k, 32'(n), 32'd0);
        tick();
        in_valid_d[k] = 1'b0;
    endtask

    task automatic wait_out(input int k);
        int n;
        n = 0;
        while (!out_valid_m[k] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("out_timeout", k, 32'(n), 32'd0);
    endtask

    task automatic recv(input int k);
        out_ready_d[k] = 1'b1;
        wait_out(k);
        tick();
    endtask

    task automatic chk_res(input string tag, input logic [17:0] xv, input logic ev);
        chk({tag, "_x"}, 1, 32'(x_m[1]), 32'(xv));
        chk({tag, "_err"}, 1, 32'(err_m[1]), 32'(ev));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid_d[k]  = 1'b0;
            q_d[k]         = 16'h0000;
            r_d[k]         = 2'd0;
            out_ready_d[k] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) tick();

        // Reset state, while reset is held and after release.
        chk("rst_in_ready", 1, 32'(in_ready_m[1]), 32'd1);
        chk("rst_out_valid", 1, 32'(out_valid_m[1]), 32'd0);
        chk_res("rst", 18'h00000, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 1, 32'(in_ready_m[1]), 32'd1);
        chk("idle_out_valid", 1, 32'(out_valid_m[1]), 32'd0);
        chk_res("idle", 18'h00000, 1'b0);

        // Zero operands.
        send(1, 16'h0000, 2'd0);
        recv(1);
        chk_res("zero", 18'h00000, 1'b0);
        chk("zero_back_idle", 1, 32'(in_ready_m[1]), 32'd1);

        // Maximum quotient and a full carry ripple.
        send(1, 16'hFFFF, 2'd2);
        recv(1);
        chk_res("max", 18'h2FFFF, 1'b0);
        send(1, 16'h5555, 2'd1);
        recv(1);
        chk_res("ripple", 18'h10000, 1'b0);

        // Illegal remainder flagged, then the flag clears on the next op.
        send(1, 16'h0001, 2'd3);
        recv(1);
        chk_res("r3", 18'h00006, 1'b1);
        send(1, 16'h0002, 2'd0);
        recv(1);
        chk_res("after_r3", 18'h00006, 1'b0);

        // Backpressure: result held, inputs ignored while DONE.
        out_ready_d[1] = 1'b0;
        send(1, 16'h00AB, 2'd1);
        wait_out(1);
        for (int i = 0; i < 5; i++) begin
            chk_res("bp_hold", 18'h00202, 1'b0);
            chk("bp_in_ready", 1, 32'(in_ready_m[1]), 32'd0);
            chk("bp_out_valid", 1, 32'(out_valid_m[1]), 32'd1);
            q_d[1] = 16'hFFFF;
            r_d[1] = 2'd3;
            in_valid_d[1] = (i % 2 == 0);
            tick();
        end
        in_valid_d[1] = 1'b0;
        out_ready_d[1] = 1'b1;
        tick();
        chk("bp_release_in_ready", 1, 32'(in_ready_m[1]), 32'd1);
        chk("bp_release_out_valid", 1, 32'(out_valid_m[1]), 32'd0);
        chk_res("bp_last_held", 18'h00202, 1'b0);
        send(1, 16'h0007, 2'd0);
        recv(1);
        chk_res("bp_next", 18'h00015, 1'b0);

        // Reset in the middle of RUN discards the operation.
        send(1, 16'hBEEF, 2'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("midrst_in_ready", 1, 32'(in_ready_m[1]), 32'd1);
        chk("midrst_out_valid", 1, 32'(out_valid_m[1]), 32'd0);
        chk_res("midrst", 18'h00000, 1'b0);
        rst = 1'b0;
        tick();
        send(1, 16'h1234, 2'd2);
        recv(1);
        chk_res("post_rst", 18'h0369E, 1'b0);

        // Random traffic on all three digit widths with input and output gaps.
        for (int c = 0; c < 30000; c++) begin
            for (int k = 0; k < 3; k++) begin
                in_valid_d[k]  = ($urandom_range(0, 3) != 0);
                q_d[k]         = 16'($urandom);
                r_d[k]         = 2'($urandom_range(0, 3));
                out_ready_d[k] = ($urandom_range(0, 2) != 0);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            in_valid_d[k]  = 1'b0;
            out_ready_d[k] = 1'b1;
        end
        repeat (40) tick();
        chk("drain", 0, 32'(g_inst[0].exp_x_q.size()), 32'd0);
        chk("drain", 1, 32'(g_inst[1].exp_x_q.size()), 32'd0);
        chk("drain", 2, 32'(g_inst[2].exp_x_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
